// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch channel: the fetch unit issues req/addr, memory answers with ack/rdata.
interface instr_fetch_unit_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
   modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, fetches words over a req/ack handshake and hands them to decode,
// with stall, branch redirect and flush (draining any request already in flight).
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_fetch_unit_if.master  mem,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [ADDR_W-1:0]   branch_target,
   input  logic                flush,
   input  logic [ADDR_W-1:0]   flush_pc,
   output logic                instr_valid,
   output logic [31:0]         instr,
   output logic [5:0]          opcode,
   output logic [5:0]          funct,
   output logic [ADDR_W-1:0]   pc_out,
   output logic [ADDR_W-1:0]   pc_plus4,
   output logic [31:0]         issue_count
);

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned CNT_W   = 32;

   typedef enum logic [1:0] {FETCH, ISSUE, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
   logic [ADDR_W-1:0]  pc_out_d;
   logic [INSTR_W-1:0] instr_d;
   logic               instr_valid_d;
   logic [CNT_W-1:0]   issue_count_d;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(3);
   endfunction

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         pc_out       <= RESET_PC;
         instr        <= '0;
         instr_valid  <= 1'b0;
         issue_count  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         pc_out       <= pc_out_d;
         instr        <= instr_d;
         instr_valid  <= instr_valid_d;
         issue_count  <= issue_count_d;
      end
   end

   // Next-state and datapath update; flush outranks every other event
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      drain_addr_d  = drain_addr_q;
      pc_out_d      = pc_out;
      instr_d       = instr;
      instr_valid_d = instr_valid;
      issue_count_d = issue_count;

      unique case (state_q)
         FETCH: begin
            if (flush) begin
               pc_d          = word_align(flush_pc);
               instr_valid_d = 1'b0;
               // A request that has not been answered yet must still complete
               if (!mem.imem_ack) begin
                  drain_addr_d = pc_q;
                  state_d      = DRAIN;
               end
            end else if (mem.imem_ack) begin
               instr_d       = mem.imem_rdata;
               pc_out_d      = pc_q;
               instr_valid_d = 1'b1;
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            if (flush) begin
               pc_d          = word_align(flush_pc);
               instr_valid_d = 1'b0;
               state_d       = FETCH;
            end else if (!stall) begin
               issue_count_d = issue_count + CNT_W'(1);
               pc_d          = branch_taken ? word_align(branch_target) : pc_q + ADDR_W'(4);
               instr_valid_d = 1'b0;
               state_d       = FETCH;
            end
         end
         DRAIN: begin
            if (flush) pc_d = word_align(flush_pc);
            if (mem.imem_ack) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Request is masked while reset is held so memory sees nothing until the first live cycle
   assign mem.imem_req  = rst_n && (state_q != ISSUE);
   assign mem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

   assign opcode   = instr[31:26];
   assign funct    = instr[5:0];
   assign pc_plus4 = pc_out + ADDR_W'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: wait-state memory model, next-fetch scoreboard and directed scenarios.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, branch_taken, flush;
   logic [31:0] branch_target, flush_pc;
   logic        instr_valid;
   logic [31:0] instr, pc_out, pc_plus4, issue_count;
   logic [5:0]  opcode, funct;

   int checks = 0;
   int errors = 0;
   int wait_cycles = 0;
   int mem_cnt = 0;

   instr_fetch_unit_if #(.ADDR_W(32)) ifc ();

   instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem          (ifc),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .opcode       (opcode),
      .funct        (funct),
      .pc_out       (pc_out),
      .pc_plus4     (pc_plus4),
      .issue_count  (issue_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h8C43_0004;
      return a ^ 32'h5A5A_0000 ^ {a[7:0], 24'h0};
   endfunction

   // Memory: answers after wait_cycles unanswered request cycles; address must hold meanwhile
   initial begin
      logic        have_prev;
      logic [31:0] prev_addr;
      have_prev = 1'b0;
      prev_addr = '0;
      ifc.imem_ack   = 1'b0;
      ifc.imem_rdata = '0;
      forever begin
         @(negedge clk);
         if (ifc.imem_req === 1'b1) begin
            if (have_prev) check("addr_stable", ifc.imem_addr, prev_addr);
            if (mem_cnt >= wait_cycles) begin
               ifc.imem_ack   = 1'b1;
               ifc.imem_rdata = mem_word(ifc.imem_addr);
               mem_cnt   = 0;
               have_prev = 1'b0;
            end else begin
               ifc.imem_ack = 1'b0;
               mem_cnt++;
               have_prev = 1'b1;
               prev_addr = ifc.imem_addr;
            end
         end else begin
            ifc.imem_ack = 1'b0;
            mem_cnt   = 0;
            have_prev = 1'b0;
         end
      end
   end

   // Scoreboard: the address of the next instruction that must reach decode is pushed when the
   // input driving that fetch is applied, and popped when instr_valid rises
   initial begin
      logic [31:0] sb_q[$];
      logic [31:0] cur_pc;
      logic        prev_valid;
      int          m_count;
      cur_pc = '0;
      prev_valid = 1'b0;
      m_count = 0;
      forever begin
         @(negedge clk);
         if (instr_valid && !prev_valid) begin
            if (sb_q.size() == 0) check("sb_unexpected_issue", pc_out, 32'hDEAD_BEEF);
            else cur_pc = sb_q.pop_front();
         end
         if (instr_valid) begin
            check("sb_pc_out", pc_out, cur_pc);
            check("sb_instr", instr, mem_word(cur_pc));
            check("sb_opcode", 32'(opcode), 32'(mem_word(cur_pc) >> 26));
            check("sb_funct", 32'(funct), mem_word(cur_pc) & 32'h3F);
            check("sb_pc_plus4", pc_plus4, cur_pc + 32'd4);
            check("sb_no_req_in_issue", 32'(ifc.imem_req), 32'd0);
         end
         check("sb_issue_count", issue_count, 32'(m_count));
         if (!rst_n) check("sb_req_in_reset", 32'(ifc.imem_req), 32'd0);
         prev_valid = instr_valid;
         if (!rst_n) begin
            sb_q.delete();
            m_count = 0;
            sb_q.push_back(32'h0);
         end else if (flush) begin
            sb_q.delete();
            sb_q.push_back({flush_pc[31:2], 2'b00});
         end else if (instr_valid && !stall) begin
            m_count++;
            sb_q.push_back(branch_taken ? {branch_target[31:2], 2'b00} : cur_pc + 32'd4);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int k;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (instr_valid) break;
      end
      check(tag, 32'(instr_valid), 32'd1);
   endtask

   task automatic wait_req_at(input string tag, input logic [31:0] a);
      int k;
      logic hit;
      hit = 1'b0;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ifc.imem_req && ifc.imem_addr == a) begin
            hit = 1'b1;
            break;
         end
      end
      check(tag, 32'(hit), 32'd1);
   endtask

   initial begin
      int          n;
      logic        found;
      logic [31:0] saved_addr;
      rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; flush = 1'b0;
      branch_target = '0; flush_pc = '0;
      repeat (3) cyc();
      rst_n = 1'b1;

      // Reset release with a zero-wait memory returning lw
      @(negedge clk);
      check("t1_req", 32'(ifc.imem_req), 32'd1);
      check("t1_addr", ifc.imem_addr, 32'h0);
      @(negedge clk);
      check("t1_valid", 32'(instr_valid), 32'd1);
      check("t1_opcode", 32'(opcode), 32'h23);
      check("t1_funct", 32'(funct), 32'h04);
      check("t1_pc_out", pc_out, 32'h0);
      check("t1_pc_plus4", pc_plus4, 32'h4);
      cyc();
      wait_cycles = 3;
      stall = 1'b1;
      @(negedge clk);
      check("t1_next_addr", ifc.imem_addr, 32'h4);
      check("t1_count", issue_count, 32'd1);

      // Three wait cycles: request held four cycles at the same address
      n = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (instr_valid) break;
         if (ifc.imem_req) n++;
      end
      check("t2_req_cycles", 32'(n), 32'd4);
      check("t2_pc_out", pc_out, 32'h4);

      // Stall in ISSUE freezes everything
      repeat (5) begin
         @(negedge clk);
         check("t3_hold_valid", 32'(instr_valid), 32'd1);
         check("t3_hold_pc", pc_out, 32'h4);
         check("t3_hold_count", issue_count, 32'd1);
      end
      cyc();
      stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t3_count", issue_count, 32'd2);
      check("t3_next_addr", ifc.imem_addr, 32'h8);

      // Flush during a waiting fetch: drain the old request, then restart at 0x100
      cyc();
      flush = 1'b1; flush_pc = 32'h0000_0103;
      cyc();
      flush = 1'b0;
      @(negedge clk);
      check("t5_drain_req", 32'(ifc.imem_req), 32'd1);
      check("t5_drain_addr", ifc.imem_addr, 32'h8);
      check("t5_drain_valid", 32'(instr_valid), 32'd0);
      wait_req_at("t5_restart_addr", 32'h100);
      cyc();
      stall = 1'b1;
      wait_valid("t5_issue_timeout");
      check("t5_pc_out", pc_out, 32'h100);

      // Branch presented while stalled is ignored until stall drops
      cyc();
      branch_taken = 1'b1; branch_target = 32'h43; wait_cycles = 0;
      repeat (3) begin
         @(negedge clk);
         check("t4_hold_pc", pc_out, 32'h100);
         check("t4_hold_count", issue_count, 32'd2);
      end
      cyc();
      stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t4_branch_addr", ifc.imem_addr, 32'h40);
      check("t4_count", issue_count, 32'd3);
      cyc();
      branch_taken = 1'b0;
      @(negedge clk);
      check("t4_pc_out", pc_out, 32'h40);

      // Flush in the same cycle as the ack: word dropped, restart at 0x100
      cyc();
      flush = 1'b1; flush_pc = 32'h100;
      @(negedge clk);
      check("t5b_addr", ifc.imem_addr, 32'h44);
      cyc();
      flush = 1'b0;
      @(negedge clk);
      check("t5b_restart", ifc.imem_addr, 32'h100);
      check("t5b_valid", 32'(instr_valid), 32'd0);

      // Reset while draining
      wait_cycles = 3;
      found = 1'b0;
      saved_addr = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (ifc.imem_req && mem_cnt == 1) begin
            found = 1'b1;
            saved_addr = ifc.imem_addr;
            break;
         end
      end
      check("t6_found_wait", 32'(found), 32'd1);
      cyc();
      flush = 1'b1; flush_pc = 32'h300;
      cyc();
      flush = 1'b0;
      @(negedge clk);
      check("t6_drain_addr", ifc.imem_addr, saved_addr);
      cyc();
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_req_reset", 32'(ifc.imem_req), 32'd0);
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_valid", 32'(instr_valid), 32'd0);
      check("t6_count", issue_count, 32'd0);
      check("t6_addr", ifc.imem_addr, 32'h0);

      // Reset while issuing
      cyc();
      stall = 1'b1;
      wait_valid("t6b_issue_timeout");
      check("t6b_pc_out", pc_out, 32'h0);
      cyc();
      rst_n = 1'b0; wait_cycles = 0;
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      check("t6b_valid", 32'(instr_valid), 32'd0);
      check("t6b_addr", ifc.imem_addr, 32'h0);

      // PC wrap at the top of the address space
      wait_valid("t7_issue0_timeout");
      cyc();
      flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
      cyc();
      flush = 1'b0;
      wait_valid("t7_issue_timeout");
      check("t7_pc_out", pc_out, 32'hFFFF_FFFC);
      check("t7_pc_plus4", pc_plus4, 32'h0);
      cyc();
      stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t7_wrap_addr", ifc.imem_addr, 32'h0);
      cyc();
      stall = 1'b1;
      wait_valid("t7_final_timeout");
      repeat (3) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
